// File: rtl/blink_pkg.sv
// Shared LED/buzzer blink definitions.
// Holds the blink FSM state type and default timing constants.
package blink_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } blink_state_t;

   // 100 ms at 50 MHz
   localparam int BLINK_ON_DEF  = 5_000_000;
   localparam int BLINK_OFF_DEF = 5_000_000;

endpackage

// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into visible LED blinks.
// Events arriving mid-blink are queued and replayed back-to-back.
module event_blinker
   import blink_pkg::*;
#(
   parameter int ON_CNT  = BLINK_ON_DEF,
   parameter int OFF_CNT = BLINK_OFF_DEF,
   parameter int PEND_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              evt_pulse,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int MAXC = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] ON_LD  = CW'(ON_CNT - 1);
   localparam logic [CW-1:0] OFF_LD = CW'(OFF_CNT - 1);

   blink_state_t      r_state;
   blink_state_t      w_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_start;
   logic              w_pend_nz;
   logic              w_full;
   logic              w_inc;
   logic              w_dec;
   logic              w_cnt_zero;

   assign w_pend_nz  = (pending != '0);
   assign w_full     = &pending;
   assign w_cnt_zero = (r_cnt == '0);

   always_comb begin
      w_nxt   = r_state;
      w_start = 1'b0;
      case (r_state)
         IDLE: begin
            w_start = evt_pulse || w_pend_nz;
         end
         ON: begin
            if (w_cnt_zero) w_nxt = OFF;
         end
         OFF: begin
            if (w_cnt_zero) begin
               if (evt_pulse || w_pend_nz) w_start = 1'b1;
               else                        w_nxt   = IDLE;
            end
         end
         default: w_nxt = IDLE;
      endcase
      if (w_start) w_nxt = ON;
   end

   // One down-counter serves both the ON and OFF phases
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_start)
         w_cnt_nxt = ON_LD;
      else if (r_state == ON && w_cnt_zero)
         w_cnt_nxt = OFF_LD;
      else if (!w_cnt_zero)
         w_cnt_nxt = r_cnt - 1'b1;
   end

   // A start drains the queue first; the pulse is consumed only when empty
   assign w_dec = w_start && w_pend_nz;
   assign w_inc = evt_pulse && !(w_start && !w_pend_nz);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         led_out  <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         led_out <= (w_nxt == ON);
         busy    <= (w_nxt != IDLE);
         if (w_inc && !w_dec) begin
            if (w_full) overflow <= 1'b1;
            else        pending  <= pending + PEND_W'(1);
         end else if (w_dec && !w_inc) begin
            pending <= pending - PEND_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_event_blinker.sv
// Directed bench for event_blinker with ON_CNT=4, OFF_CNT=3, PEND_W=2.
// Cycle 0 is the first cycle after reset is released.
module tb_event_blinker;

   logic       clk;
   logic       reset;
   logic       evt_pulse;
   logic       led_out;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int n_pass;
   int n_total;

   event_blinker #(
      .ON_CNT (4),
      .OFF_CNT(3),
      .PEND_W (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .evt_pulse(evt_pulse),
      .led_out  (led_out),
      .busy     (busy),
      .pending  (pending),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit in_rng(int c, int a, int b);
      return (c >= a) && (c <= b);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      evt_pulse = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      evt_pulse = 1'b1;
      step();
      step();
      n_total++;
      if ({led_out, busy, pending, overflow} !== 5'b0) begin
         $display("FAIL reset: got %b want 00000",
                  {led_out, busy, pending, overflow});
      end else n_pass++;
      reset     = 1'b0;
      evt_pulse = 1'b0;
      step();
      n_total++;
      if ({led_out, busy, pending, overflow} !== 5'b0) begin
         $display("FAIL reset_idle: got %b want 00000",
                  {led_out, busy, pending, overflow});
      end else n_pass++;
   endtask

   task automatic test_single();
      logic [4:0] e;
      do_reset();
      for (int c = 0; c <= 22; c++) begin
         evt_pulse = (c == 10);
         e = {in_rng(c, 11, 14), in_rng(c, 11, 17), 2'd0, 1'b0};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL single c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
   endtask

   task automatic test_burst();
      logic [4:0] e;
      logic [1:0] p;
      do_reset();
      for (int c = 0; c <= 36; c++) begin
         evt_pulse = in_rng(c, 10, 12);
         p = (c == 12) ? 2'd1 :
             in_rng(c, 13, 17) ? 2'd2 :
             in_rng(c, 18, 24) ? 2'd1 : 2'd0;
         e = {in_rng(c, 11, 14) || in_rng(c, 18, 21) || in_rng(c, 25, 28),
              in_rng(c, 11, 31), p, 1'b0};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL burst c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
   endtask

   task automatic test_overflow();
      logic [4:0] e;
      logic [1:0] p;
      do_reset();
      for (int c = 0; c <= 42; c++) begin
         evt_pulse = in_rng(c, 10, 14);
         p = (c == 12) ? 2'd1 :
             (c == 13) ? 2'd2 :
             in_rng(c, 14, 17) ? 2'd3 :
             in_rng(c, 18, 24) ? 2'd2 :
             in_rng(c, 25, 31) ? 2'd1 : 2'd0;
         e = {in_rng(c, 11, 14) || in_rng(c, 18, 21) ||
              in_rng(c, 25, 28) || in_rng(c, 32, 35),
              in_rng(c, 11, 38), p, (c >= 15)};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL overflow c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
   endtask

   task automatic test_inc_dec();
      logic [4:0] e;
      do_reset();
      for (int c = 0; c <= 34; c++) begin
         evt_pulse = (c == 10) || (c == 11) || (c == 17);
         e = {in_rng(c, 11, 14) || in_rng(c, 18, 21) || in_rng(c, 25, 28),
              in_rng(c, 11, 31),
              in_rng(c, 12, 24) ? 2'd1 : 2'd0, 1'b0};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL inc_dec c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [4:0] e;
      do_reset();
      for (int c = 0; c <= 25; c++) begin
         evt_pulse = in_rng(c, 10, 12);
         reset     = (c == 12);
         e = {in_rng(c, 11, 12), in_rng(c, 11, 12),
              (c == 12) ? 2'd1 : 2'd0, 1'b0};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL reset_mid c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] e;
      do_reset();
      for (int c = 0; c <= 28; c++) begin
         evt_pulse = (c == 10) || (c == 17);
         e = {in_rng(c, 11, 14) || in_rng(c, 18, 21),
              in_rng(c, 11, 24), 2'd0, 1'b0};
         n_total++;
         if ({led_out, busy, pending, overflow} !== e) begin
            $display("FAIL back_to_back c=%0d: got %b want %b",
                     c, {led_out, busy, pending, overflow}, e);
         end else n_pass++;
         step();
      end
      evt_pulse = 1'b0;
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      reset     = 1'b1;
      evt_pulse = 1'b0;
      #2;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_inc_dec();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
